kuz_round_pipe: RTL and testbench
=================================

Name: kuz_round_pipe

Overview:
Parametrised Kuznyechik (GOST R 34.12-2015) round engine computing LSX[k](a) for one 128-bit block per accepted beat.
- Replaces the fixed 18-register free-running stage with a configurable-depth pipeline.
- Adds valid/ready flow control per register, an ID tag carried alongside each block, and a final-round (X-only) mode.
- Sits between the round scheduler (which supplies the block, round key and tag) and the key-expansion/round-iteration controller.

Parameters:
R_PER_STAGE, 4, number of R-steps of L combined per pipeline register; legal values 1, 2, 4, 8, 16 (elaboration error otherwise)
ID_W, 4, width of the opaque tag carried with each block
N_L, 16/R_PER_STAGE, derived: number of L pipeline registers
LAT, 2+N_L, derived: pipeline depth in registers (X, S, then N_L)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid_i  in  1  input beat valid
in_ready_o  out  1  engine can accept a beat this cycle
data_i  in  128  block a; byte a15 = bits[127:120]
key_i  in  128  round key k, sampled with data_i
last_i  in  1  1 = final round: output X[k](a) only, S and L bypassed
id_i  in  ID_W  tag, returned unchanged with the result
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
data_o  out  128  LSX[k](a), or X[k](a) when the beat had last_i=1
id_o  out  ID_W  tag of the result
last_o  out  1  last_i of the result
occupancy_o  out  $clog2(LAT+1)  number of valid entries held in the pipeline

Behaviour:
- Reset (async assert, sync deassert by the system): all stage valid bits, data, key-derived and tag registers go to 0; out_valid_o=0, data_o=0, id_o=0, last_o=0, occupancy_o=0. Reset mid-operation discards all in-flight beats with no output.
- Stage 0 registers a^k together with last and id. Stage 1 registers S(x): per-byte pi substitution via the shared lookup, or x unchanged if last. Stages 2..LAT-1 each apply R_PER_STAGE R-steps, or pass through if last.
- R-step: R(a15..a0) = l(a15..a0) || a15..a1, i.e. out[127:120] = l and out[119:0] = in[127:8].
  - l = 148a15+32a14+133a13+16a12+194a11+192a10+1a9+251a8+1a7+192a6+194a5+16a4+133a3+32a2+148a1+1a0.
  - Arithmetic is over GF(2^8) mod x^8+x^7+x^6+x+1 (0x1C3); + is XOR.
- Flow control is per stage with bubble collapse. ready_k = !valid_k || ready_{k+1}; ready_LAT = out_ready_i; in_ready_o = ready_0.
  - Stage k loads from k-1 (or from the inputs for k=0) when ready_k=1. Its valid becomes valid_{k-1} (in_valid_i for k=0).
  - A stage holds its data and valid when ready_k=0.
- out_valid_o = valid of the last stage. data_o, id_o and last_o are driven directly from last-stage registers and stay stable while out_valid_o=1 and out_ready_i=0.
- Latency is exactly LAT cycles from an accepted input to out_valid_o, given an unstalled pipeline. Throughput is 1 beat/cycle while out_ready_i=1.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- occupancy_o counts valid stages: +1 on input accept, -1 on output accept, unchanged on a simultaneous accept. Range is 0..LAT.
- Full pipeline with out_ready_i=0: in_ready_o=0 and no register changes.
- Full pipeline with out_ready_i=1: accept and emit in the same cycle.
- The ready chain is a combinational path through LAT stages. This is accepted for LAT<=18.

Test Plan:
- Reset, then key_i=8899aabbccddeeff0011223344556677, data_i=1122334455667700ffeeddccbbaa9988, last_i=0, id_i=3 -> after 6 cycles (default) out_valid_o=1, data_o=e297b686e355b0a1cf4a2f9249140830, id_o=3, occupancy_o=1 before the output handshake.
- Same data with last_i=1 -> data_o=99bb99ff99bb99ffffffffffffffffff, last_o=1, same latency.
- R_PER_STAGE=16 and =1 builds with the first vector -> identical data_o; latency 3 and 18 cycles respectively.
- 20 back-to-back beats (id 0..19, random data and key) with out_ready_i=1 -> outputs one per cycle, in id order, each matching the software model; in_ready_o stays 1.
- Hold out_ready_i=0 while streaming -> occupancy_o rises to LAT, then in_ready_o=0 and data_o/id_o hold stable. Release -> all beats drain in order; inserted bubbles collapse.
- Assert rst_n=0 with 4 beats in flight -> out_valid_o=0, occupancy_o=0 immediately (asynchronous); after release no stale beats appear.

Source files
------------

// File: rtl/kuz_round_pipe.sv
// Kuznyechik round engine: computes LSX[k](a) for one 128-bit block per beat.
// The first register holds X = a ^ k and the second holds S(X). N_L more registers
// each apply R_PER_STAGE R-steps of L. When the beat's last flag is set, only X is
// applied and the S and L stages pass the block through. Each register has its own
// valid bit. The ready chain lets bubbles collapse, so a stall at the output fills
// every stage before the input is refused.
module kuz_round_pipe #(
    parameter int R_PER_STAGE  = 4,
    parameter int ID_W         = 4,
    localparam int N_L         = 16 / R_PER_STAGE,
    localparam int LAT         = 2 + N_L,
    localparam int OCC_W       = $clog2(LAT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [127:0]      data_i,
    input  logic [127:0]      key_i,
    input  logic              last_i,
    input  logic [ID_W-1:0]   id_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [127:0]      data_o,
    output logic [ID_W-1:0]   id_o,
    output logic              last_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    if (!(R_PER_STAGE == 1 || R_PER_STAGE == 2 || R_PER_STAGE == 4 ||
          R_PER_STAGE == 8 || R_PER_STAGE == 16)) begin : g_bad_r_per_stage
        $error("kuz_round_pipe: R_PER_STAGE must be 1, 2, 4, 8 or 16");
    end

    // Kuznyechik pi substitution. All 16 byte lanes of the S stage use this table.
    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Coefficients of the linear function l, indexed by byte number (a0 = bits[7:0]).
    localparam logic [7:0] L_COEF [16] = '{
        8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
        8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
    };

    // GF(2^8) product modulo x^8+x^7+x^6+x+1. The carry-less product is formed
    // first and then reduced from the top bit down. Every call here has a constant
    // b, so each multiply reduces to a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'(9'h1C3) << (i - 8));
        end
        return p[7:0];
    endfunction

    // One R-step: l of all 16 bytes enters at the top and the block shifts down a byte.
    function automatic logic [127:0] r_step(input logic [127:0] a);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ gf_mul(a[8*i +: 8], L_COEF[i]);
        end
        return {acc, a[127:8]};
    endfunction

    // The share of L that one L register is responsible for.
    function automatic logic [127:0] l_slice(input logic [127:0] a);
        logic [127:0] t;
        t = a;
        for (int i = 0; i < R_PER_STAGE; i++) begin
            t = r_step(t);
        end
        return t;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] a);
        logic [127:0] t;
        for (int i = 0; i < 16; i++) begin
            t[8*i +: 8] = PI[a[8*i +: 8]];
        end
        return t;
    endfunction

    logic [LAT-1:0]  stage_valid;
    logic [LAT-1:0]  stage_last;
    logic [127:0]    stage_data [LAT];
    logic [ID_W-1:0] stage_id   [LAT];

    logic [LAT:0]    ready;
    logic [LAT-1:0]  src_valid;
    logic [LAT-1:0]  src_last;
    logic [127:0]    src_data   [LAT];
    logic [ID_W-1:0] src_id     [LAT];

    logic in_fire;
    logic out_fire;

    // Ready chain: a stage can load if it is empty or its successor is loading.
    always_comb begin
        logic chain;
        // NOTE: every variable an always_comb writes gets a value before any branch. Otherwise a path that skips it infers a latch.
        ready = '0;
        chain = out_ready_i;
        ready[LAT] = chain;
        for (int k = LAT - 1; k >= 0; k--) begin
            chain = !stage_valid[k] || chain;
            ready[k] = chain;
        end
    end

    // What each stage would capture this cycle: X from the ports, then S, then L slices.
    always_comb begin
        src_valid = '0;
        src_last  = '0;
        for (int k = 0; k < LAT; k++) begin
            src_data[k] = '0;
            src_id[k]   = '0;
        end

        src_valid[0] = in_valid_i;
        src_last[0]  = last_i;
        src_data[0]  = data_i ^ key_i;
        src_id[0]    = id_i;

        for (int k = 1; k < LAT; k++) begin
            src_valid[k] = stage_valid[k-1];
            src_last[k]  = stage_last[k-1];
            src_id[k]    = stage_id[k-1];
            if (stage_last[k-1]) begin
                src_data[k] = stage_data[k-1];
            end else if (k == 1) begin
                src_data[k] = sub_bytes(stage_data[k-1]);
            end else begin
                src_data[k] = l_slice(stage_data[k-1]);
            end
        end
    end

    // Pipeline registers. A stage loads on ready and otherwise holds its contents.
    // Its payload is written only when a valid beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload registers are reset as well as the valid bits, so data_o/id_o/last_o read 0 after reset.
            stage_valid <= '0;
            stage_last  <= '0;
            for (int k = 0; k < LAT; k++) begin
                stage_data[k] <= '0;
                stage_id[k]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every stage sees its predecessor's old value.
            for (int k = 0; k < LAT; k++) begin
                if (ready[k]) begin
                    stage_valid[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        stage_data[k] <= src_data[k];
                        stage_last[k] <= src_last[k];
                        stage_id[k]   <= src_id[k];
                    end
                end
            end
        end
    end

    assign in_fire  = in_valid_i && ready[0];
    assign out_fire = stage_valid[LAT-1] && out_ready_i;

    // Occupancy tracks accepted-but-not-emitted beats. A simultaneous accept and emit leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy_o <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy_o <= occupancy_o + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occupancy_o <= occupancy_o - OCC_W'(1);
        end
    end

    assign in_ready_o  = ready[0];
    assign out_valid_o = stage_valid[LAT-1];
    assign data_o      = stage_data[LAT-1];
    assign id_o        = stage_id[LAT-1];
    assign last_o      = stage_last[LAT-1];

endmodule

// File: tb/tb_kuz_round_pipe.sv
// Self-checking bench for kuz_round_pipe. Three engines share the inputs:
// R_PER_STAGE = 4 (default), 16 and 1. A reference LSX model supplies the
// expected blocks for the random streams.
module tb_kuz_round_pipe;

    localparam int LAT0  = 6;
    localparam int LAT16 = 3;
    localparam int LAT1  = 18;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         last_in;
    logic [7:0]   id_in;
    logic         out_ready;

    logic         in_ready, in_ready_16, in_ready_1;
    logic         out_valid, out_valid_16, out_valid_1;
    logic [127:0] data_out, data_out_16, data_out_1;
    logic [7:0]   id_out, id_out_16, id_out_1;
    logic         last_out, last_out_16, last_out_1;
    logic [2:0]   occ;
    logic [1:0]   occ_16;
    logic [4:0]   occ_1;

    int n_checks = 0;
    int n_fail   = 0;

    kuz_round_pipe #(.R_PER_STAGE(4), .ID_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .data_i(data_in), .key_i(key_in), .last_i(last_in), .id_i(id_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(data_out),
        .id_o(id_out), .last_o(last_out), .occupancy_o(occ)
    );

    kuz_round_pipe #(.R_PER_STAGE(16), .ID_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_16),
        .data_i(data_in), .key_i(key_in), .last_i(last_in), .id_i(id_in),
        .out_valid_o(out_valid_16), .out_ready_i(out_ready), .data_o(data_out_16),
        .id_o(id_out_16), .last_o(last_out_16), .occupancy_o(occ_16)
    );

    kuz_round_pipe #(.R_PER_STAGE(1), .ID_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_1),
        .data_i(data_in), .key_i(key_in), .last_i(last_in), .id_i(id_in),
        .out_valid_o(out_valid_1), .out_ready_i(out_ready), .data_o(data_out_1),
        .id_o(id_out_1), .last_o(last_out_1), .occupancy_o(occ_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // l coefficients in written order a15 .. a0.
    localparam logic [7:0] L_HI_FIRST [16] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic         last;
        logic [7:0]   id;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   id;
        logic         last;
    } beat_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_lsx(input logic [127:0] a, input logic [127:0] k,
                                               input logic fin);
        logic [127:0] x;
        logic [7:0]   l;
        x = a ^ k;
        if (fin) return x;
        for (int j = 0; j < 16; j++) x[127-8*j -: 8] = PI[x[127-8*j -: 8]];
        for (int r = 0; r < 16; r++) begin
            l = 8'h00;
            for (int j = 0; j < 16; j++) l = l ^ gmul(x[127-8*j -: 8], L_HI_FIRST[j]);
            x = {l, x[127:8]};
        end
        return x;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        key_in    = '0;
        last_in   = 1'b0;
        id_in     = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Streams n_beats through the default engine. Each cycle it checks ready, occupancy
    // and the head-of-queue result. The output stalls for stall_cycles, and input
    // bubbles are inserted on request.
    task automatic run_stream(input int n_beats, input int stall_cycles, input bit bubbles,
                              input bit rand_last, input string tag);
        beat_t q[$];
        beat_t b;
        bit    pending;
        bit    fire_in, fire_out;
        int    sent, cyc, first_out, last_out_cyc, n_out, max_occ;
        pending = 1'b0; sent = 0; cyc = 0; first_out = -1; last_out_cyc = -1; n_out = 0; max_occ = 0;
        while ((sent < n_beats || q.size() > 0) && cyc < 400) begin
            out_ready = (cyc >= stall_cycles);
            if (!pending && sent < n_beats && (!bubbles || (cyc % 3) != 2)) begin
                data_in = rnd128();
                key_in  = rnd128();
                last_in = rand_last && ($urandom_range(0, 3) == 0);
                id_in   = 8'(sent);
                pending = 1'b1;
            end
            in_valid = pending;
            @(negedge clk);
            check({tag, " in_ready"}, 128'(in_ready), 128'(out_ready || (q.size() < LAT0)));
            check({tag, " occupancy"}, 128'(occ), 128'(q.size()));
            if (q.size() > max_occ) max_occ = q.size();
            fire_out = out_valid && out_ready;
            fire_in  = in_valid && in_ready;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s spurious output: got id %0h, expected no valid output", tag, id_out);
                end else begin
                    check({tag, " data_o"}, data_out, q[0].data);
                    check({tag, " id_o"}, 128'(id_out), 128'(q[0].id));
                    check({tag, " last_o"}, 128'(last_out), 128'(q[0].last));
                end
            end
            if (fire_out && q.size() > 0) begin
                void'(q.pop_front());
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out_cyc = cyc;
            end
            if (fire_in) begin
                b.data = model_lsx(data_in, key_in, last_in);
                b.id   = id_in;
                b.last = last_in;
                q.push_back(b);
                pending = 1'b0;
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, " beats emitted"}, 128'(n_out), 128'(n_beats));
        if (stall_cycles == 0 && !bubbles)
            check({tag, " back-to-back span"}, 128'(last_out_cyc - first_out), 128'(n_beats - 1));
        if (stall_cycles > 0)
            check({tag, " peak occupancy"}, 128'(max_occ), 128'(LAT0));
    endtask

    vec_t vecs [5];

    initial begin
        int lat, lat16, lat1;

        vecs[0] = '{128'h1122334455667700ffeeddccbbaa9988, 128'h8899aabbccddeeff0011223344556677,
                    1'b0, 8'h03, 128'he297b686e355b0a1cf4a2f9249140830};
        vecs[1] = '{128'h1122334455667700ffeeddccbbaa9988, 128'h8899aabbccddeeff0011223344556677,
                    1'b1, 8'h07, 128'h99bb99ff99bb99ffffffffffffffffff};
        vecs[2] = '{128'hffffffffffffffffffffffffffffffff, 128'h0123456789abcdeffedcba9876543210,
                    1'b1, 8'hA5, 128'hfedcba98765432100123456789abcdef};
        vecs[3] = '{128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
                    1'b1, 8'hFF, 128'h0};
        vecs[4] = '{128'h99bb99ff99bb99ffffffffffffffffff, 128'h0,
                    1'b0, 8'h00, 128'he297b686e355b0a1cf4a2f9249140830};

        // Reset values.
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; data_in = '0; key_in = '0; last_in = 1'b0; id_in = '0;
        @(negedge clk);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset data_o", data_out, 128'd0);
        check("reset id_o", 128'(id_out), 128'd0);
        check("reset last_o", 128'(last_out), 128'd0);
        check("reset occupancy", 128'(occ), 128'd0);
        check("reset in_ready", 128'(in_ready), 128'd1);
        apply_reset();

        // Single beats, default engine: latency, result, tag and handshake.
        for (int v = 0; v < 5; v++) begin
            data_in  = vecs[v].data;
            key_in   = vecs[v].key;
            last_in  = vecs[v].last;
            id_in    = vecs[v].id;
            in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d in_ready", v), 128'(in_ready), 128'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    lat = c;
                    break;
                end
                @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d latency", v), 128'(lat), 128'(LAT0));
            check($sformatf("vec%0d data_o", v), data_out, vecs[v].exp);
            check($sformatf("vec%0d id_o", v), 128'(id_out), 128'(vecs[v].id));
            check($sformatf("vec%0d last_o", v), 128'(last_out), 128'(vecs[v].last));
            check($sformatf("vec%0d occupancy", v), 128'(occ), 128'd1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d drained valid", v), 128'(out_valid), 128'd0);
            check($sformatf("vec%0d drained occupancy", v), 128'(occ), 128'd0);
            @(posedge clk);
            #1;
        end

        // Other depths: same result, latency 3 and 18.
        apply_reset();
        data_in = vecs[0].data; key_in = vecs[0].key; last_in = 1'b0; id_in = 8'h03;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat16 = 0;
        lat1  = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (out_valid_16 && lat16 == 0) lat16 = c;
            if (out_valid_1 && lat1 == 0) lat1 = c;
            if (lat16 != 0 && lat1 != 0) break;
            @(posedge clk);
            #1;
        end
        check("r16 latency", 128'(lat16), 128'(LAT16));
        check("r1 latency", 128'(lat1), 128'(LAT1));
        check("r16 data_o", data_out_16, vecs[0].exp);
        check("r1 data_o", data_out_1, vecs[0].exp);
        check("r16 id_o", 128'(id_out_16), 128'h03);
        check("r1 id_o", 128'(id_out_1), 128'h03);
        check("r16 occupancy", 128'(occ_16), 128'd1);
        check("r1 occupancy", 128'(occ_1), 128'd1);
        @(posedge clk);
        #1;

        // Full-rate stream, then a stalled stream with bubbles and mixed final rounds.
        apply_reset();
        run_stream(20, 0, 1'b0, 1'b0, "stream");
        apply_reset();
        run_stream(16, 20, 1'b1, 1'b1, "stall");

        // Asynchronous reset with four beats in flight.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            data_in = rnd128(); key_in = rnd128(); last_in = 1'b0; id_in = 8'(i + 1);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("pre-reset occupancy", 128'(occ), 128'd4);
        check("pre-reset out_valid", 128'(out_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 128'(out_valid), 128'd0);
        check("async reset occupancy", 128'(occ), 128'd0);
        check("async reset data_o", data_out, 128'd0);
        check("async reset id_o", 128'(id_out), 128'd0);
        check("async reset r1 occupancy", 128'(occ_1), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("post-reset stale c%0d", c), 128'(out_valid), 128'd0);
        end
        check("post-reset occupancy", 128'(occ), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
